// File: rtl/fifo_pkg.sv
// Shared constants, pointer-width helper and status struct for the synchronous FIFO.
// Consumers import this with: import fifo_pkg::*;
package fifo_pkg;

  // Default configuration: 8-bit x 16-deep, almost-full at 12, almost-empty at 4
  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAddrW = 4;
  localparam int unsigned DefAfLvl = 12;
  localparam int unsigned DefAeLvl = 4;

  // Pointers carry one extra wrap bit above the memory address
  function automatic int unsigned ptr_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  // Bundled status view for upstream consumers
  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port storage array: synchronous write, asynchronous read, no reset.
module fifo_dpram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  // Write port: store on accepted write only
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, synchronous flush and sticky
// overflow/underflow flags.
// Optional build macro SYNC_FIFO_FWFT_EN selects first-word fall-through output;
// when undefined, data_out is a register loaded on each accepted read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned AF_LVL = DefAfLvl,
  parameter int unsigned AE_LVL = DefAeLvl
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              rd,
  input  logic              clr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_almost_full,
  output logic              fifo_almost_empty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              fifo_overflow,
  output logic              fifo_underflow
);

  localparam int unsigned PtrW = ptr_w(ADDR_W);
  localparam logic [PtrW-1:0] AfLvl = PtrW'(AF_LVL);
  localparam logic [PtrW-1:0] AeLvl = PtrW'(AE_LVL);

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic [ADDR_W-1:0] waddr, raddr;
  logic [DATA_W-1:0] rdata;
  logic              full, empty;
  logic              we, re;
  fifo_status_t      status;

  assign waddr = wptr_q[ADDR_W-1:0];
  assign raddr = rptr_q[ADDR_W-1:0];

  // Full/empty come from registered pointers only, so no path from wr/rd to any flag
  assign full  = (waddr == raddr) && (wptr_q[PtrW-1] != rptr_q[PtrW-1]);
  assign empty = (wptr_q == rptr_q);

  // Flush wins over any request in the same cycle, including the memory write
  assign we = wr & ~full & ~clr;
  assign re = rd & ~empty & ~clr;

  fifo_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (data_in),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Next-state for pointers, occupancy and sticky error flags
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (we) wptr_d = wptr_q + PtrW'(1);
      if (re) rptr_d = rptr_q + PtrW'(1);
      case ({we, re})
        2'b10:   count_d = count_q + PtrW'(1);
        2'b01:   count_d = count_q - PtrW'(1);
        default: count_d = count_q;
      endcase
      if (wr && full)  ovf_d = 1'b1;
      if (rd && empty) unf_d = 1'b1;
    end
  end

  // State registers with asynchronous reset to the same state as a flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Status decode from registered state
  always_comb begin
    status           = '0;
    status.full      = full;
    status.empty     = empty;
    status.afull     = (count_q >= AfLvl);
    status.aempty    = (count_q <= AeLvl);
    status.overflow  = ovf_q;
    status.underflow = unf_q;
  end

  assign fifo_full         = status.full;
  assign fifo_empty        = status.empty;
  assign fifo_almost_full  = status.afull;
  assign fifo_almost_empty = status.aempty;
  assign fifo_overflow     = status.overflow;
  assign fifo_underflow    = status.underflow;
  assign fifo_count        = count_q;

`ifdef SYNC_FIFO_FWFT_EN
  // Head word falls through; forced to 0 while empty so reset/flush read back as 0
  assign data_out = empty ? '0 : rdata;
`else
  logic [DATA_W-1:0] dout_q;

  // Registered read port: loads the head on each accepted read, holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (clr) begin
      dout_q <= '0;
    end else if (re) begin
      dout_q <= rdata;
    end
  end

  assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at default parameters. Read data is checked by a
// scoreboard monitor; flags and count are compared against a bench-side occupancy model.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr, rd, clr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
  logic [4:0] fifo_count;
  logic       fifo_overflow, fifo_underflow;

  int total = 0;
  int bad   = 0;

  // Bench model
  logic [7:0] exp_q[$];
  int         mcount = 0;
  logic       movf = 1'b0;
  logic       munf = 1'b0;

  sync_fifo_param dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wr                (wr),
    .rd                (rd),
    .clr               (clr),
    .data_in           (data_in),
    .data_out          (data_out),
    .fifo_full         (fifo_full),
    .fifo_empty        (fifo_empty),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_count        (fifo_count),
    .fifo_overflow     (fifo_overflow),
    .fifo_underflow    (fifo_underflow)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".count"},  32'(fifo_count), 32'(mcount));
    chk({tag, ".full"},   32'(fifo_full), 32'(mcount == 16));
    chk({tag, ".empty"},  32'(fifo_empty), 32'(mcount == 0));
    chk({tag, ".afull"},  32'(fifo_almost_full), 32'(mcount >= 12));
    chk({tag, ".aempty"}, 32'(fifo_almost_empty), 32'(mcount <= 4));
    chk({tag, ".ovf"},    32'(fifo_overflow), 32'(movf));
    chk({tag, ".unf"},    32'(fifo_underflow), 32'(munf));
  endtask

  task automatic model_reset();
    mcount = 0;
    movf   = 1'b0;
    munf   = 1'b0;
    exp_q.delete();
  endtask

  // One clock of stimulus; the model is updated and expected data queued before the edge
  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    bit wacc, racc;
    wr = w; rd = r; clr = c; data_in = d;
    if (c) begin
      model_reset();
    end else begin
      wacc = w && (mcount < 16);
      racc = r && (mcount > 0);
      if (w && mcount == 16) movf = 1'b1;
      if (r && mcount == 0)  munf = 1'b1;
      if (wacc) exp_q.push_back(d);
      mcount = mcount + int'(wacc) - int'(racc);
    end
    @(posedge clk);
    #2;
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  // Scoreboard monitor: compares read data whenever the DUT accepts a read
  initial begin
    logic [7:0] sample;
    logic [7:0] expv;
    forever begin
      @(posedge clk);
      if (rst_n && !clr && rd && !fifo_empty) begin
`ifdef SYNC_FIFO_FWFT_EN
        sample = data_out;
`else
        #1 sample = data_out;
`endif
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_underrun: got %0h expected none", sample);
        end else begin
          expv = exp_q.pop_front();
          if (sample !== expv) begin
            bad++;
            $display("FAIL sb_data: got %0h expected %0h", sample, expv);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0; data_in = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    chk("rst.data_out", 32'(data_out), 32'h0);
    chk_status("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 0x00..0x0F, then one write while full
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(i));
      chk_status("fill");
    end
    chk("fill.full16", 32'(fifo_full), 32'h1);
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    chk("ovf.set", 32'(fifo_overflow), 32'h1);
    chk_status("ovf");

    // Drain; scoreboard checks the 0x00..0x0F order, 0xEE must never appear
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk_status("drain");
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("unf.set", 32'(fifo_underflow), 32'h1);
    chk_status("unf");
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("clr.data_out", 32'(data_out), 32'h0);
    chk_status("clr1");

    // Simultaneous wr & rd when full and when empty
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
    step(1'b1, 1'b1, 1'b0, 8'hEE);
    chk("wr_rd_full.count", 32'(fifo_count), 32'd15);
    chk_status("wr_rd_full");
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h77);
    chk("wr_rd_empty.count", 32'(fifo_count), 32'd1);
    chk_status("wr_rd_empty");
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Streaming at count 3 across pointer wrap
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(8'h50 + i));
      chk_status("stream");
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk_status("stream_drain");

    // Flush at count 9 together with wr & rd
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h69);
    step(1'b1, 1'b1, 1'b1, 8'h99);
    chk("clr9.data_out", 32'(data_out), 32'h0);
    chk("clr9.count", 32'(fifo_count), 32'h0);
    chk_status("clr9");

    // Asynchronous reset mid-burst at count 7
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.data_out", 32'(data_out), 32'h0);
    chk_status("arst");
    @(negedge clk);
    rst_n = 1'b1;

    // Single write: head visible after the write edge in fall-through mode
    step(1'b1, 1'b0, 1'b0, 8'hA5);
    chk("a5.empty", 32'(fifo_empty), 32'h0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("a5.fwft_head", 32'(data_out), 32'hA5);
`endif
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk_status("a5_read");
`ifndef SYNC_FIFO_FWFT_EN
    chk("a5.hold", 32'(data_out), 32'hA5);
`endif
    chk("sb.empty_at_end", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
